// File: rtl/spi_mem_master_p.sv
// SPI mode-0 master that performs single-word reads/writes to an addressed slave memory.
// Frame (MSB first): 1 direction bit (1 = write), ADDR_W address bits, DATA_W data bits.
module spi_mem_master_p #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] dout,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
    localparam int unsigned CMP_W   = ADDR_W + 1;

    // One extra bit so DEPTH = 2**ADDR_W is representable and never flags an error.
    localparam logic [CMP_W-1:0] DEPTH_V    = CMP_W'(DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(1 + ADDR_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [FRAME_W-1:0]  tx, tx_d;
    logic [DATA_W-1:0]   rx, rx_d;
    logic [DIV_W-1:0]    div_cnt, div_d;
    logic [BIT_W-1:0]    bit_cnt, bit_d;
    logic                busy_d, done_d, err_d, cs_d, sclk_d, mosi_d;
    logic [DATA_W-1:0]   dout_d;
    logic                req_addr_ok_c;
    logic                lat_addr_ok_c;

    // Address range checks against the incoming and the latched address.
    always_comb begin
        req_addr_ok_c = (CMP_W'(addr) < DEPTH_V);
        lat_addr_ok_c = (CMP_W'(addr_q) < DEPTH_V);
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            tx      <= '0;
            rx      <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            dout    <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            state   <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            tx      <= tx_d;
            rx      <= rx_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            dout    <= dout_d;
            cs      <= cs_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d = state;
        wr_d    = wr_q;
        addr_d  = addr_q;
        tx_d    = tx;
        rx_d    = rx;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dout_d  = dout;
        cs_d    = cs;
        sclk_d  = sclk;
        mosi_d  = mosi;

        case (state)
            IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    tx_d    = {wr, addr, (wr ? din : {DATA_W{1'b0}})};
                    // Select the slave already in the check cycle when the address is valid.
                    cs_d    = ~req_addr_ok_c;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (!lat_addr_ok_c) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    // First bit is presented at the start of its low phase.
                    mosi_d  = tx[FRAME_W-1];
                    tx_d    = {tx[FRAME_W-2:0], 1'b0};
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk) begin
                        // Rising edge: capture read data during the data field.
                        sclk_d = 1'b1;
                        if (!wr_q && (bit_cnt >= DATA_FIRST)) begin
                            rx_d = (rx << 1) | DATA_W'(miso);
                        end
                    end else begin
                        // Falling edge: advance to the next bit or close the frame.
                        sclk_d = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            mosi_d  = 1'b0;
                            cs_d    = 1'b1;
                            done_d  = 1'b1;
                            if (!wr_q) begin
                                dout_d = rx;
                            end
                            state_d = DONE;
                        end else begin
                            bit_d  = bit_cnt + BIT_W'(1);
                            mosi_d = tx[FRAME_W-1];
                            tx_d   = {tx[FRAME_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spi_mem_master_p.sv
// Self-checking bench: two instances (8/8-bit with DEPTH=128, CLK_DIV=2 and 16/4-bit with
// CLK_DIV=1), table vectors, randomized transactions against a frame-level model, reset abort.
module tb_spi_mem_master_p;

    logic clk;
    logic rst_n;

    logic        req_a, wr_a, busy_a, done_a, err_a, cs_a, sclk_a, mosi_a, miso_a;
    logic [7:0]  addr_a, din_a, dout_a;
    logic        req_b, wr_b, busy_b, done_b, err_b, cs_b, sclk_b, mosi_b, miso_b;
    logic [3:0]  addr_b;
    logic [15:0] din_b, dout_b;

    spi_mem_master_p #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst_n), .req(req_a), .wr(wr_a), .addr(addr_a), .din(din_a),
        .busy(busy_a), .done(done_a), .err(err_a), .dout(dout_a),
        .cs(cs_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_mem_master_p #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_n), .req(req_b), .wr(wr_b), .addr(addr_b), .din(din_b),
        .busy(busy_b), .done(done_b), .err(err_b), .dout(dout_b),
        .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
        end
    endtask

    // ---------------- slave models and bus monitors ----------------
    int          rise_a, rise_b;
    logic [63:0] frame_a, frame_b;
    logic [7:0]  slv_a;
    logic [15:0] slv_b;

    always @(posedge sclk_a) if (!cs_a) begin
        frame_a = {frame_a[62:0], mosi_a};
        rise_a  = rise_a + 1;
    end

    always @(posedge sclk_b) if (!cs_b) begin
        frame_b = {frame_b[62:0], mosi_b};
        rise_b  = rise_b + 1;
    end

    // Slave returns its word MSB first over the data-field rising edges; 1 elsewhere.
    always_comb begin
        miso_a = 1'b1;
        if (rise_a >= 9 && rise_a < 17) miso_a = slv_a[3'(16 - rise_a)];
    end

    always_comb begin
        miso_b = 1'b1;
        if (rise_b >= 5 && rise_b < 21) miso_b = slv_b[4'(20 - rise_b)];
    end

    int   viol_a, viol_b, ndone_a;
    logic mosi_prev_a, mosi_prev_b;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((done_a || err_a) && !cs_a) viol_a++;
            if (err_a && !done_a) viol_a++;
            if (mosi_a !== mosi_prev_a && sclk_a) viol_a++;
            if ((done_b || err_b) && !cs_b) viol_b++;
            if (err_b && !done_b) viol_b++;
            if (mosi_b !== mosi_prev_b && sclk_b) viol_b++;
        end
        if (done_a) ndone_a++;
        mosi_prev_a = mosi_a;
        mosi_prev_b = mosi_b;
    end

    // ---------------- reference model ----------------
    localparam int DEPTH_A = 128;
    localparam int LAT_A   = 2 + 2 * 2 * 17;
    localparam int LAT_B   = 2 + 2 * 1 * 21;

    function automatic logic [63:0] model_frame_a(logic w, logic [7:0] a, logic [7:0] d);
        if (int'(a) >= DEPTH_A) return 64'd0;
        return (64'(w) << 16) | (64'(a) << 8) | (w ? 64'(d) : 64'd0);
    endfunction

    function automatic logic [63:0] model_frame_b(logic w, logic [3:0] a, logic [15:0] d);
        return (64'(w) << 20) | (64'(a) << 16) | (w ? 64'(d) : 64'd0);
    endfunction

    // One transaction on instance A; reports latency (-1 on timeout) and observations.
    task automatic run_a(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] s, output int lat, output logic e,
                         output logic [63:0] fr, output int np, output logic [7:0] dq,
                         output logic cs1, output logic busy_ok);
        @(negedge clk);
        wr_a = w; addr_a = a; din_a = d; slv_a = s;
        rise_a = 0; frame_a = '0;
        req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wr_a = 1'($urandom); addr_a = 8'($urandom); din_a = 8'($urandom);
        lat = -1; e = 1'b0; dq = '0; cs1 = 1'b1; busy_ok = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) cs1 = cs_a;
            if (!busy_a) busy_ok = 1'b0;
            if (done_a) begin
                lat = k; e = err_a; dq = dout_a;
                if (!cs_a || sclk_a) busy_ok = 1'b0;
                break;
            end
        end
        fr = frame_a;
        np = rise_a;
        @(negedge clk);
        if (busy_a || done_a) busy_ok = 1'b0;
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] s;
        logic       e;
        int         lat;
        logic [7:0] dq;
    } vec_t;

    vec_t        tbl[7];
    logic [7:0]  exp_dout_a;
    logic [15:0] exp_dout_b;
    int          lat, np, nd0;
    logic        e, cs1, bok;
    logic [63:0] fr;
    logic [7:0]  dq;
    logic [15:0] dq_b;
    logic        bw[4];
    logic [3:0]  ba[4];
    logic [15:0] bd[4];
    logic [15:0] bs[4];

    initial begin
        n_cmp = 0; n_bad = 0;
        viol_a = 0; viol_b = 0; ndone_a = 0;
        rise_a = 0; rise_b = 0; frame_a = '0; frame_b = '0;
        slv_a = '0; slv_b = '0;
        req_a = 0; wr_a = 0; addr_a = '0; din_a = '0;
        req_b = 0; wr_b = 0; addr_b = '0; din_b = '0;
        rst_n = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_a_ctrl", {cs_a, sclk_a, mosi_a, busy_a, done_a, err_a}, 6'b100000);
        chk("rst_a_dout", dout_a, 8'h00);
        chk("rst_b_ctrl", {cs_b, sclk_b, mosi_b, busy_b, done_b, err_b}, 6'b100000);
        chk("rst_b_dout", dout_b, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_dout_a = 8'h00;
        exp_dout_b = 16'h0000;

        // Directed vectors: {wr, addr, din, slave word, err, latency, dout after}
        tbl[0] = '{1'b1, 8'h12, 8'hA5, 8'h77, 1'b0, LAT_A, 8'h00};
        tbl[1] = '{1'b0, 8'h34, 8'hFF, 8'h5C, 1'b0, LAT_A, 8'h5C};
        tbl[2] = '{1'b0, 8'h80, 8'h11, 8'h99, 1'b1, 2,     8'h5C};
        tbl[3] = '{1'b1, 8'h7F, 8'h3C, 8'h00, 1'b0, LAT_A, 8'h5C};
        tbl[4] = '{1'b0, 8'h7F, 8'h00, 8'hC3, 1'b0, LAT_A, 8'hC3};
        tbl[5] = '{1'b0, 8'hFF, 8'h00, 8'h12, 1'b1, 2,     8'hC3};
        tbl[6] = '{1'b1, 8'h00, 8'h81, 8'hFF, 1'b0, LAT_A, 8'hC3};

        for (int i = 0; i < 7; i++) begin
            run_a(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, lat, e, fr, np, dq, cs1, bok);
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
            chk($sformatf("tbl%0d_dout", i), dq, tbl[i].dq);
            chk($sformatf("tbl%0d_cs_t1", i), cs1, tbl[i].e);
            chk($sformatf("tbl%0d_frame", i), fr, model_frame_a(tbl[i].w, tbl[i].a, tbl[i].d));
            chk($sformatf("tbl%0d_pulses", i), 64'(np), tbl[i].e ? 64'd0 : 64'd17);
            chk($sformatf("tbl%0d_busy", i), bok, 1'b1);
        end
        exp_dout_a = 8'hC3;

        // Randomized transactions against the model
        for (int i = 0; i < 20; i++) begin
            logic       w, bad;
            logic [7:0] a, d, s;
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            s = 8'($urandom);
            bad = (int'(a) >= DEPTH_A);
            if (!bad && !w) exp_dout_a = s;
            run_a(w, a, d, s, lat, e, fr, np, dq, cs1, bok);
            chk($sformatf("rnd%0d_latency", i), 64'(lat), bad ? 64'd2 : 64'(LAT_A));
            chk($sformatf("rnd%0d_err", i), e, bad);
            chk($sformatf("rnd%0d_dout", i), dq, exp_dout_a);
            chk($sformatf("rnd%0d_frame", i), fr, model_frame_a(w, a, d));
            chk($sformatf("rnd%0d_pulses", i), 64'(np), bad ? 64'd0 : 64'd17);
            chk($sformatf("rnd%0d_busy", i), bok, 1'b1);
        end

        // Reset in the middle of a frame, at the 9th sclk pulse
        @(negedge clk);
        wr_a = 1'b1; addr_a = 8'h21; din_a = 8'h96; slv_a = 8'h00;
        rise_a = 0; frame_a = '0;
        req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        for (int k = 0; k < 200 && rise_a < 9; k++) @(negedge clk);
        chk("rst_mid_reached_pulse9", 64'(rise_a), 64'd9);
        nd0 = ndone_a;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {cs_a, sclk_a, mosi_a, busy_a, done_a, err_a}, 6'b100000);
        chk("rst_mid_dout", dout_a, 8'h00);
        exp_dout_a = 8'h00;
        exp_dout_b = 16'h0000;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", 64'(ndone_a), 64'(nd0));
        chk("rst_mid_idle", busy_a, 1'b0);
        run_a(1'b1, 8'h05, 8'h5A, 8'hEE, lat, e, fr, np, dq, cs1, bok);
        chk("post_rst_latency", 64'(lat), 64'(LAT_A));
        chk("post_rst_err", e, 1'b0);
        chk("post_rst_frame", fr, model_frame_a(1'b1, 8'h05, 8'h5A));
        chk("post_rst_dout", dq, 8'h00);
        chk("post_rst_pulses", 64'(np), 64'd17);

        // Back-to-back frames on instance B with req held high throughout
        for (int i = 0; i < 4; i++) begin
            bw[i] = 1'($urandom_range(0, 1));
            ba[i] = 4'($urandom);
            bd[i] = 16'($urandom);
            bs[i] = 16'($urandom);
        end
        bw[0] = 1'b0;
        bw[1] = 1'b1;
        @(negedge clk);
        wr_b = bw[0]; addr_b = ba[0]; din_b = bd[0]; slv_b = bs[0];
        req_b = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            int lat_b;
            rise_b = 0; frame_b = '0;
            wr_b = 1'($urandom); addr_b = 4'($urandom); din_b = 16'($urandom);
            lat_b = -1; e = 1'b0; dq_b = '0;
            for (int k = 1; k <= 100; k++) begin
                @(negedge clk);
                if (done_b) begin
                    lat_b = k; e = err_b; dq_b = dout_b;
                    break;
                end
            end
            if (!bw[i]) exp_dout_b = bs[i];
            chk($sformatf("b2b%0d_latency", i), 64'(lat_b), 64'(LAT_B));
            chk($sformatf("b2b%0d_err", i), e, 1'b0);
            chk($sformatf("b2b%0d_frame", i), frame_b, model_frame_b(bw[i], ba[i], bd[i]));
            chk($sformatf("b2b%0d_pulses", i), 64'(rise_b), 64'd21);
            chk($sformatf("b2b%0d_dout", i), dq_b, exp_dout_b);
            if (i < 3) begin
                wr_b = bw[i+1]; addr_b = ba[i+1]; din_b = bd[i+1]; slv_b = bs[i+1];
            end else begin
                req_b = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("b2b%0d_idle_gap", i), busy_b, 1'b0);
            @(posedge clk);
            #1;
        end

        repeat (4) @(negedge clk);
        chk("protocol_a", 64'(viol_a), 64'd0);
        chk("protocol_b", 64'(viol_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_mem_master_p.md
SPI_MEM_MASTER_P -- requirements
Module: spi_mem_master_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per transfer (>=1).
REQ-002 SHALL have parameter ADDR_W, default 8, address bits per transfer (>=1).
REQ-003 SHALL have parameter DEPTH, default 256, number of valid slave addresses (1..2**ADDR_W).
REQ-004 SHALL have parameter CLK_DIV, default 2, clk cycles per sclk half-period (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  1  transaction request, sampled only in IDLE.
REQ-008 SHALL have port wr  input  1  1 = write, 0 = read; latched with req.
REQ-009 SHALL have port addr  input  ADDR_W  target address; latched with req.
REQ-010 SHALL have port din  input  DATA_W  write data; latched with req.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  one-cycle error pulse, only together with done.
REQ-014 SHALL have port dout  output  DATA_W  last read data.
REQ-015 SHALL have port cs  output  1  active-low chip select to slave.
REQ-016 SHALL have port sclk  output  1  serial clock, idle low (SPI mode 0).
REQ-017 SHALL have port mosi  output  1  serial data to slave.
REQ-018 SHALL have port miso  input  1  serial data from slave.

Function
REQ-019 SHALL implement states IDLE, CHECK, SHIFT, DONE.
REQ-020 IDLE with req=1 at cycle T: latch wr/addr/din; go to CHECK; req ignored in all other states.
REQ-021 CHECK (cycle T+1): addr >= DEPTH -> DONE with err; else cs low from T+1, go to SHIFT.
REQ-022 Error path: done=err=1 at T+2; cs, sclk, mosi never toggle; dout unchanged.
REQ-023 Frame, MSB first, N = 1+ADDR_W+DATA_W bits: bit0 = wr, then addr, then data field.
REQ-024 Each bit: sclk low CLK_DIV cycles, then high CLK_DIV cycles; 2*CLK_DIV*N cycles per frame.
REQ-025 mosi SHALL change only while sclk is low, set at the start of each bit's low phase.
REQ-026 Write: data field driven from latched din; miso ignored.
REQ-027 Read: mosi=0 during data field; miso sampled on each sclk rising edge of the data field.
REQ-028 After the last high phase: sclk low, cs high, state DONE, done=1 at cycle T+2+2*CLK_DIV*N (defaults: T+70).
REQ-029 Read: dout SHALL update with sampled data in the done cycle; write: dout unchanged.
REQ-030 DONE lasts exactly one cycle, then IDLE; done and err SHALL never be high while cs is low.
REQ-031 busy=1 from T+1 through the done cycle inclusive; req in the cycle after done is accepted.
REQ-032 Bit and divider counters SHALL be sized from N and CLK_DIV; no truncation at parameter maxima.
REQ-033 addr = DEPTH-1 SHALL be valid; addr = DEPTH SHALL error; DEPTH = 2**ADDR_W never errors.

Reset
REQ-034 rst low SHALL immediately force IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, err=0, dout=0.
REQ-035 Reset mid-frame SHALL abort with no done pulse; first req after release starts a fresh frame.

Verification
REQ-036 Defaults, write addr=0x12 din=0xA5 -> mosi bits 1,0x12,0xA5; 17 sclk pulses; done at T+70; err=0.
REQ-037 Read addr=0x34, slave drives 0x5C on miso -> mosi bit0=0; dout=0x5C in done cycle; err=0.
REQ-038 DEPTH=128, req addr=0x80 -> done=err=1 at T+2, cs stays high, no sclk edges.
REQ-039 DEPTH=128, req addr=0x7F -> normal frame, err=0.
REQ-040 rst low at sclk pulse 9 -> cs=1, sclk=0 at once; no done; next write completes correctly.
REQ-041 DATA_W=16, ADDR_W=4, CLK_DIV=1, back-to-back reqs -> 21-bit frames, each done at T+44, req held during busy ignored.
